// File: rtl/range_monitor.sv
// range_monitor: windowed check of a sampled value bus with sticky alarm.
// Optional embedded checker enabled by defining RANGE_MON_ASSERT_EN.
module range_monitor #(
    parameter int DATA_W  = 4,
    parameter int LO      = 4,
    parameter int HI      = 11,
    parameter int PERSIST = 2,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    input  logic              clear,
    output logic              in_range,
    output logic              alarm,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  viol_count,
    output logic [DATA_W-1:0] min_seen,
    output logic [DATA_W-1:0] max_seen
);

    if (LO > HI) begin : g_bad_window
        $fatal(1, "range_monitor: LO > HI");
    end
    if (PERSIST < 1) begin : g_bad_persist
        $fatal(1, "range_monitor: PERSIST < 1");
    end

    localparam int RUN_W = $clog2(PERSIST + 1);
    localparam logic [RUN_W-1:0]  RUN_MAX = RUN_W'(PERSIST);
    localparam logic [DATA_W-1:0] LO_V    = DATA_W'(LO);
    localparam logic [DATA_W-1:0] HI_V    = DATA_W'(HI);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OK      = 2'd1,
        SUSPECT = 2'd2,
        ALARM   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              in_range_q, in_range_d;
    logic [CNT_W-1:0]  viol_q, viol_d;
    logic [DATA_W-1:0] min_q, min_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic              oor;

    assign oor = (sample_data < LO_V) || (sample_data > HI_V);

    // Next-state, statistics and run tracking for each accepted sample.
    always_comb begin
        state_d    = state_q;
        in_range_d = in_range_q;
        viol_d     = viol_q;
        min_d      = min_q;
        max_d      = max_q;
        run_d      = run_q;
        if (clear) begin
            state_d    = IDLE;
            in_range_d = 1'b0;
            viol_d     = '0;
            min_d      = '1;
            max_d      = '0;
            run_d      = '0;
        end else if (sample_valid) begin
            in_range_d = ~oor;
            if (sample_data < min_q) min_d = sample_data;
            if (sample_data > max_q) max_d = sample_data;
            if (oor) begin
                if (viol_q != '1) viol_d = viol_q + 1'b1;
                if (run_q != RUN_MAX) run_d = run_q + 1'b1;
            end else begin
                run_d = '0;
            end
            unique case (state_q)
                IDLE, OK, SUSPECT: begin
                    if (!oor)                state_d = OK;
                    else if (run_d == RUN_MAX) state_d = ALARM;
                    else                     state_d = SUSPECT;
                end
                ALARM: state_d = ALARM;
            endcase
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            in_range_q <= 1'b0;
            viol_q     <= '0;
            min_q      <= '1;
            max_q      <= '0;
            run_q      <= '0;
        end else begin
            state_q    <= state_d;
            in_range_q <= in_range_d;
            viol_q     <= viol_d;
            min_q      <= min_d;
            max_q      <= max_d;
            run_q      <= run_d;
        end
    end

    assign in_range   = in_range_q;
    assign alarm      = (state_q == ALARM);
    assign state      = state_q;
    assign viol_count = viol_q;
    assign min_seen   = min_q;
    assign max_seen   = max_q;

`ifdef RANGE_MON_ASSERT_EN
    // Embedded invariant checker; IDLE means no sample since reset/clear.
    always_ff @(posedge clk) begin
        if (reset_n && !clear) begin
            if (state_q == ALARM)
                assert (state_d == ALARM)
                    else $error("range_monitor: left ALARM");
            assert (viol_d >= viol_q)
                else $error("range_monitor: viol_count decremented");
            if (state_q != IDLE)
                assert (min_q <= max_q)
                    else $error("range_monitor: min_seen > max_seen");
            if (state_q != ALARM && state_d == ALARM)
                $error("range_monitor alarm: %0d", sample_data);
        end
    end
`endif

endmodule

// File: tb/tb_range_monitor.sv
// Directed self-checking bench for range_monitor.
// Second instance uses CNT_W=2 to exercise counter saturation.
module tb_range_monitor;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sample_valid = 1'b0;
    logic [3:0] sample_data = '0;
    logic       clear = 1'b0;

    logic       in_range, alarm;
    logic [1:0] state;
    logic [7:0] viol_count;
    logic [3:0] min_seen, max_seen;

    logic       in_range2, alarm2;
    logic [1:0] state2;
    logic [1:0] viol_count2;
    logic [3:0] min_seen2, max_seen2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    range_monitor dut (
        .clk(clk), .reset_n(reset_n),
        .sample_valid(sample_valid), .sample_data(sample_data),
        .clear(clear), .in_range(in_range), .alarm(alarm),
        .state(state), .viol_count(viol_count),
        .min_seen(min_seen), .max_seen(max_seen)
    );

    range_monitor #(.CNT_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n),
        .sample_valid(sample_valid), .sample_data(sample_data),
        .clear(clear), .in_range(in_range2), .alarm(alarm2),
        .state(state2), .viol_count(viol_count2),
        .min_seen(min_seen2), .max_seen(max_seen2)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock with given inputs; returns 1ns after the edge.
    task automatic step(input logic v, input logic [3:0] d, input logic c);
        @(negedge clk);
        sample_valid = v;
        sample_data  = d;
        clear        = c;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        clear        = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", state, 0);
        chk("rst_in_range", in_range, 0);
        chk("rst_alarm", alarm, 0);
        chk("rst_viol", viol_count, 0);
        chk("rst_min", min_seen, 15);
        chk("rst_max", max_seen, 0);
        @(negedge clk);
        reset_n = 1'b1;

        step(1, 4, 0);
        chk("lo_legal", in_range, 1);
        step(1, 11, 0);
        chk("hi_legal", in_range, 1);
        step(1, 7, 0);
        chk("ok_state", state, 1);
        chk("ok_in_range", in_range, 1);
        chk("ok_viol", viol_count, 0);
        chk("ok_min", min_seen, 4);
        chk("ok_max", max_seen, 11);
        chk("ok_alarm", alarm, 0);

        step(1, 12, 0);
        chk("s12_state", state, 2);
        chk("s12_in_range", in_range, 0);
        step(1, 5, 0);
        chk("s5_state", state, 1);
        step(1, 3, 0);
        chk("s3_state", state, 2);
        chk("s3_viol", viol_count, 2);
        chk("s3_alarm", alarm, 0);
        chk("s3_min", min_seen, 3);

        step(1, 6, 0);
        chk("s6_state", state, 1);
        step(1, 13, 0);
        chk("s13_state", state, 2);
        chk("s13_alarm", alarm, 0);
        step(0, 0, 0);
        chk("idle_state", state, 2);
        chk("idle_viol", viol_count, 3);
        step(1, 0, 0);
        chk("s0_alarm", alarm, 1);
        chk("s0_state", state, 3);
        chk("s0_min", min_seen, 0);
        chk("s0_max", max_seen, 13);
        step(1, 8, 0);
        chk("s8_alarm", alarm, 1);
        chk("s8_in_range", in_range, 1);
        chk("s8_viol", viol_count, 4);

        step(1, 14, 1);
        chk("clr_state", state, 0);
        chk("clr_viol", viol_count, 0);
        chk("clr_min", min_seen, 15);
        chk("clr_max", max_seen, 0);
        chk("clr_alarm", alarm, 0);
        chk("clr_in_range", in_range, 0);

        for (int i = 0; i < 5; i++) step(1, 15, 0);
        chk("sat_viol2", viol_count2, 3);
        chk("sat_max2", max_seen2, 15);
        chk("sat_viol", viol_count, 5);
        chk("sat_state", state, 3);

        step(0, 0, 1);
        step(1, 12, 0);
        chk("pre_rst_state", state, 2);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_state", state, 0);
        chk("arst_viol", viol_count, 0);
        chk("arst_max", max_seen, 0);
        chk("arst_min", min_seen, 15);
        #1;
        reset_n = 1'b1;
        step(1, 9, 0);
        chk("post_state", state, 1);
        chk("post_in_range", in_range, 1);
        chk("post_run", alarm, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/range_monitor.md
Name: range_monitor

Overview:
- Downstream consumer of a 4-bit registered value bus, such as the register output of the chk block.
- Samples the bus on a valid strobe and checks each sample against an inclusive window [LO, HI].
- Tracks consecutive out-of-range runs and raises a sticky alarm after PERSIST consecutive violations.
- Keeps a saturating violation count and min/max statistics, all readable by the surrounding design or a testbench.

Parameters:
- DATA_W, 4: sample width (unsigned).
- LO, 4: inclusive lower bound of the legal window.
- HI, 11: inclusive upper bound of the legal window.
- PERSIST, 2: number of consecutive out-of-range valid samples that trigger the alarm (>=1).
- CNT_W, 8: width of the violation counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- sample_valid  input  1  sample_data is sampled this cycle.
- sample_data  input  DATA_W  value under check.
- clear  input  1  synchronous clear of all statistics and the alarm.
- in_range  output  1  result for the last accepted sample.
- alarm  output  1  sticky alarm.
- state  output  2  FSM state: IDLE=0, OK=1, SUSPECT=2, ALARM=3.
- viol_count  output  CNT_W  total out-of-range samples, saturating.
- min_seen  output  DATA_W  smallest accepted sample.
- max_seen  output  DATA_W  largest accepted sample.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset_n low, asynchronous assert, synchronous release):
  - state=IDLE, in_range=0, alarm=0, viol_count=0.
  - min_seen=all ones, max_seen=0.
  - Internal run counter = 0.
- Out-of-range test: sample_data < LO or sample_data > HI, unsigned compare. LO and HI themselves are legal.
- Latency: all outputs are registered and reflect an accepted sample on the cycle after it is accepted.
- Cycles with sample_valid=0 change nothing; they do not break a run.
- On every accepted sample:
  - min_seen/max_seen update.
  - in_range = NOT out-of-range.
  - If out-of-range, viol_count increments; it holds at 2^CNT_W-1 once saturated (no wrap).
- Run counter:
  - Increments on each out-of-range accepted sample.
  - Reset to 0 by an in-range accepted sample.
  - Saturates at PERSIST.
- FSM transitions, evaluated on accepted samples only:
  - IDLE: in-range -> OK; out-of-range -> SUSPECT, or ALARM if PERSIST=1.
  - OK: in-range -> OK; out-of-range -> SUSPECT, or ALARM if PERSIST=1.
  - SUSPECT: in-range -> OK; out-of-range with run reaching PERSIST -> ALARM; otherwise stay SUSPECT.
  - ALARM: absorbing until clear or reset. In-range samples do not leave ALARM but still update statistics and in_range.
- alarm = (state==ALARM). It asserts the cycle after the PERSIST-th consecutive out-of-range sample.
- clear=1:
  - Next cycle, all outputs and the run counter return to reset values.
  - clear wins over a simultaneous sample_valid; that sample is discarded and not counted.
- reset_n asserted mid-run: everything returns to reset values immediately, independent of clk.
- Elaboration: LO>HI or PERSIST<1 is a fatal elaboration error.

Optional Feature:
- Macro RANGE_MON_ASSERT_EN.
- Defined: the block embeds a checker that, on every non-reset clock edge, asserts:
  - state never leaves ALARM except via clear or reset;
  - viol_count never decrements except via clear or reset;
  - when any sample has been accepted, min_seen <= max_seen.
  - It also issues $error("range_monitor alarm: %0d", sample_data) on the cycle ALARM is entered.
- Undefined: no assertion or simulation-only code is compiled; functional behaviour is identical.

Test Plan:
- Reset, then valid samples 4, 11, 7 -> state=OK, in_range=1, viol_count=0, min_seen=4, max_seen=11, alarm=0.
- Samples 12, then 5, then 3 -> SUSPECT after 12, OK after 5, SUSPECT after 3. viol_count=2, alarm=0 (no two consecutive violations).
- Samples 13, idle cycle, 0 -> alarm=1 one cycle after 0, state=ALARM. A following sample 8 leaves alarm=1 and sets in_range=1.
- With CNT_W=2, five consecutive out-of-range samples of 15 -> viol_count saturates at 3, max_seen=15.
- clear and sample_valid with data 14 in the same cycle -> next cycle state=IDLE, viol_count=0, min_seen=15, max_seen=0, alarm=0; the sample of 14 is ignored.
- reset_n pulsed low between clock edges while in SUSPECT -> outputs go to reset values immediately. First sample 9 after release -> state=OK.
